cook_timer: RTL and testbench

Downstream consumer of the cook-time setter's 10-bit `input_time` (minutes).
- Loads the set time on a start press and counts down in MM:SS at 1 Hz.
- Drives the heater enable while running.
- Raises a timed alarm at zero.
- Exposes four BCD digits for the HEX display drivers.
- Provides pause, resume and cancel via a second button.

---
 rtl/cook_timer_if.sv | 33 +++
 rtl/cook_timer.sv | 202 ++++++++++++++++++++
 tb/tb_cook_timer.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cook_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : cook_timer_if
//  Description : Signal bundle between the cook timer and its surroundings:
//                set time and buttons in, FSM state, heater/alarm and the
//                four BCD display digits out.
//  Revision    : 1.0  initial release
// ============================================================================
interface cook_timer_if;
  logic [9:0] input_time;
  logic       btnstart;
  logic       btnstop;
  logic [1:0] state;
  logic       heater_on;
  logic       alarm;
  logic [3:0] min_tens;
  logic [3:0] min_units;
  logic [3:0] sec_tens;
  logic [3:0] sec_units;

  // Environment side: drives time and buttons, observes the timer
  modport master (
    output input_time, btnstart, btnstop,
    input  state, heater_on, alarm, min_tens, min_units, sec_tens, sec_units
  );

  // Timer side
  modport slave (
    input  input_time, btnstart, btnstop,
    output state, heater_on, alarm, min_tens, min_units, sec_tens, sec_units
  );
endinterface
`default_nettype wire

// File: rtl/cook_timer.sv
`default_nettype none
// ============================================================================
//  Module      : cook_timer
//  Description : MM:SS countdown cook timer. Loads min(input_time,99) minutes
//                on start, counts down at one tick per CLK_HZ cycles, drives
//                the heater while running, raises a timed alarm at zero and
//                supports pause / resume / cancel / acknowledge.
//  Revision    : 1.0  initial release
// ============================================================================
module cook_timer #(
  parameter int CLK_HZ    = 50000000,
  parameter int ALARM_SEC = 3
) (
  input  logic        clock,
  input  logic        reset,
  cook_timer_if.slave bus
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int AW = (ALARM_SEC > 0) ? $clog2(ALARM_SEC + 1) : 1;

  localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_HZ - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SEC - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Button synchronisers: two metastability flops, a history flop, and a
  // registered one-cycle press pulse on the falling edge of the synced pin.
  logic start_s1_q, start_s2_q, start_h_q, start_p_q;
  logic stop_s1_q, stop_s2_q, stop_h_q, stop_p_q;

  logic [1:0]    state_q, state_d;
  logic          heater_q, alarm_q;
  logic [3:0]    mt_q, mu_q, st_q, su_q;
  logic [3:0]    mt_d, mu_d, st_d, su_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [AW-1:0] acnt_q, acnt_d;

  logic [6:0] clamp;
  logic [3:0] clamp_tens, clamp_units;
  logic [3:0] dec_mt, dec_mu, dec_st, dec_su;
  logic       at_one;
  logic       tick;

  // Synchronise both active-low pins and form press pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      start_s1_q <= 1'b1;
      start_s2_q <= 1'b1;
      start_h_q  <= 1'b1;
      start_p_q  <= 1'b0;
      stop_s1_q  <= 1'b1;
      stop_s2_q  <= 1'b1;
      stop_h_q   <= 1'b1;
      stop_p_q   <= 1'b0;
    end else begin
      start_s1_q <= bus.btnstart;
      start_s2_q <= start_s1_q;
      start_h_q  <= start_s2_q;
      start_p_q  <= ~start_s2_q & start_h_q;
      stop_s1_q  <= bus.btnstop;
      stop_s2_q  <= stop_s1_q;
      stop_h_q   <= stop_s2_q;
      stop_p_q   <= ~stop_s2_q & stop_h_q;
    end
  end

  // The display only has two minute digits, so anything above 99 saturates
  assign clamp       = (bus.input_time > 10'd99) ? 7'd99 : bus.input_time[6:0];
  assign clamp_tens  = 4'(clamp / 7'd10);
  assign clamp_units = 4'(clamp % 7'd10);

  assign tick   = (pre_q == PRE_LAST);
  assign at_one = (mt_q == 4'd0) && (mu_q == 4'd0) && (st_q == 4'd0) && (su_q == 4'd1);

  // One-second BCD decrement of MM:SS with borrow through each digit
  always_comb begin
    dec_mt = mt_q;
    dec_mu = mu_q;
    dec_st = st_q;
    dec_su = su_q;
    if (su_q != 4'd0) begin
      dec_su = su_q - 4'd1;
    end else begin
      dec_su = 4'd9;
      if (st_q != 4'd0) begin
        dec_st = st_q - 4'd1;
      end else begin
        dec_st = 4'd5;
        if (mu_q != 4'd0) begin
          dec_mu = mu_q - 4'd1;
        end else begin
          dec_mu = 4'd9;
          dec_mt = mt_q - 4'd1;
        end
      end
    end
  end

  // Next-state logic; a stop pulse always outranks a start pulse
  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    mu_d    = mu_q;
    st_d    = st_q;
    su_d    = su_q;
    pre_d   = pre_q;
    acnt_d  = acnt_q;
    case (state_q)
      S_IDLE: begin
        mt_d = clamp_tens;
        mu_d = clamp_units;
        st_d = 4'd0;
        su_d = 4'd0;
        if (!stop_p_q && start_p_q && (clamp != 7'd0)) begin
          state_d = S_RUN;
          pre_d   = '0;
        end
      end
      S_RUN: begin
        // Stop freezes everything, including the partial second
        if (stop_p_q) begin
          state_d = S_PAUSE;
        end else begin
          pre_d = tick ? '0 : pre_q + PW'(1);
          if (tick) begin
            mt_d = dec_mt;
            mu_d = dec_mu;
            st_d = dec_st;
            su_d = dec_su;
            if (at_one) begin
              state_d = S_DONE;
              pre_d   = '0;
              acnt_d  = '0;
            end
          end
        end
      end
      S_PAUSE: begin
        if (stop_p_q) begin
          state_d = S_IDLE;
        end else if (start_p_q) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (stop_p_q || start_p_q) begin
          state_d = S_IDLE;
        end else begin
          pre_d = tick ? '0 : pre_q + PW'(1);
          if (tick) begin
            if (acnt_q == ALARM_LAST) begin
              state_d = S_IDLE;
              acnt_d  = '0;
            end else begin
              acnt_d = acnt_q + AW'(1);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters, digits and the decoded heater/alarm outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      heater_q <= 1'b0;
      alarm_q  <= 1'b0;
      mt_q     <= 4'd0;
      mu_q     <= 4'd0;
      st_q     <= 4'd0;
      su_q     <= 4'd0;
      pre_q    <= '0;
      acnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      heater_q <= (state_d == S_RUN);
      alarm_q  <= (state_d == S_DONE);
      mt_q     <= mt_d;
      mu_q     <= mu_d;
      st_q     <= st_d;
      su_q     <= su_d;
      pre_q    <= pre_d;
      acnt_q   <= acnt_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.heater_on = heater_q;
  assign bus.alarm     = alarm_q;
  assign bus.min_tens  = mt_q;
  assign bus.min_units = mu_q;
  assign bus.sec_tens  = st_q;
  assign bus.sec_units = su_q;

endmodule
`default_nettype wire

// File: tb/tb_cook_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cook_timer
//  Description : Self-checking bench for cook_timer with a seconds-level
//                behavioural model of the timer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cook_timer;
  localparam int CLK_HZ    = 4;
  localparam int ALARM_SEC = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  cook_timer_if tif ();

  cook_timer #(.CLK_HZ(CLK_HZ), .ALARM_SEC(ALARM_SEC)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (tif)
  );

  always #5 clk = ~clk;

  logic [19:0] dut_vec;
  assign dut_vec = {tif.state, tif.heater_on, tif.alarm,
                    tif.min_tens, tif.min_units, tif.sec_tens, tif.sec_units};

  // Reference model: remaining time kept as plain seconds, prescaler as a
  // phase within the second, presses seen as pin falls three edges back.
  int m_state = 0;
  int m_disp  = 0;
  int m_phase = 0;
  int m_acnt  = 0;
  bit st_hist [5];
  bit sp_hist [5];

  always @(posedge clk) begin : p_model
    int clampv;
    bit sta, stp, tk;
    clampv = (int'(tif.input_time) > 99) ? 99 : int'(tif.input_time);
    if (rst) begin
      m_state = 0; m_disp = 0; m_phase = 0; m_acnt = 0;
      for (int i = 0; i < 5; i++) begin st_hist[i] = 1'b1; sp_hist[i] = 1'b1; end
    end else begin
      for (int i = 4; i > 0; i--) begin st_hist[i] = st_hist[i-1]; sp_hist[i] = sp_hist[i-1]; end
      st_hist[0] = tif.btnstart;
      sp_hist[0] = tif.btnstop;
      sta = !st_hist[3] && st_hist[4];
      stp = !sp_hist[3] && sp_hist[4];
      tk  = (m_phase == CLK_HZ - 1);
      case (m_state)
        0: begin
          if (!stp && sta && clampv != 0) begin m_state = 1; m_phase = 0; end
          m_disp = clampv * 60;
        end
        1: begin
          if (stp) m_state = 2;
          else begin
            m_phase = tk ? 0 : m_phase + 1;
            if (tk) begin
              m_disp = m_disp - 1;
              if (m_disp == 0) begin m_state = 3; m_acnt = 0; end
            end
          end
        end
        2: begin
          if (stp) m_state = 0;
          else if (sta) m_state = 1;
        end
        default: begin
          if (stp || sta) m_state = 0;
          else begin
            m_phase = tk ? 0 : m_phase + 1;
            if (tk) begin
              m_acnt = m_acnt + 1;
              if (m_acnt == ALARM_SEC) begin m_state = 0; m_acnt = 0; end
            end
          end
        end
      endcase
    end
  end

  function automatic logic [19:0] exp_vec();
    int mm, ss;
    mm = m_disp / 60;
    ss = m_disp % 60;
    return {2'(m_state), (m_state == 1), (m_state == 3),
            4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  // Stimulus only: fall the chosen pins, hold past the reaction, release
  task automatic press(input bit s, input bit p);
    if (s) tif.btnstart = 1'b0;
    if (p) tif.btnstop  = 1'b0;
    repeat (4) @(negedge clk);
    tif.btnstart = 1'b1;
    tif.btnstop  = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    tif.input_time = 10'd5;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (dut_vec !== 20'h0) begin bad++; $display("FAIL reset_state got=%h want=%h", dut_vec, 20'h0); end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (dut_vec !== {2'd0, 1'b0, 1'b0, 16'h0500}) begin bad++; $display("FAIL reset_track got=%h want=%h", dut_vec, {2'd0, 2'b00, 16'h0500}); end
    total++;
    if (dut_vec !== exp_vec()) begin bad++; $display("FAIL reset_model got=%h want=%h", dut_vec, exp_vec()); end
  endtask

  task automatic test_run_borrow();
    tif.input_time = 10'd2;
    @(negedge clk);
    tif.btnstart = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (tif.state !== 2'd0) begin bad++; $display("FAIL start_early got=%0d want=0", tif.state); end
    @(negedge clk);
    tif.btnstart = 1'b1;
    total++;
    if (dut_vec !== {2'd1, 1'b1, 1'b0, 16'h0200}) begin bad++; $display("FAIL run_load got=%h want=%h", dut_vec, {2'd1, 2'b10, 16'h0200}); end
    repeat (CLK_HZ) @(negedge clk);
    total++;
    if (dut_vec[15:0] !== 16'h0159) begin bad++; $display("FAIL first_tick got=%h want=0159", dut_vec[15:0]); end
    for (int i = 0; i < 59 * CLK_HZ; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== exp_vec()) begin bad++; $display("FAIL run_track cyc=%0d got=%h want=%h", i, dut_vec, exp_vec()); end
    end
    total++;
    if (dut_vec !== {2'd1, 1'b1, 1'b0, 16'h0100}) begin bad++; $display("FAIL borrow_chain got=%h want=%h", dut_vec, {2'd1, 2'b10, 16'h0100}); end
    press(1'b0, 1'b1);
    total++;
    if (tif.state !== 2'd2 || tif.heater_on !== 1'b0) begin bad++; $display("FAIL run_pause got=%0d/%0d want=2/0", tif.state, tif.heater_on); end
    press(1'b0, 1'b1);
    total++;
    if (dut_vec !== exp_vec() || tif.state !== 2'd0) begin bad++; $display("FAIL cancel got=%h want=%h", dut_vec, exp_vec()); end
  endtask

  task automatic test_idle_edges();
    tif.input_time = 10'd0;
    @(negedge clk);
    press(1'b1, 1'b0);
    total++;
    if (tif.state !== 2'd0 || tif.heater_on !== 1'b0) begin bad++; $display("FAIL zero_start got=%0d/%0d want=0/0", tif.state, tif.heater_on); end
    tif.input_time = 10'd300;
    @(negedge clk);
    press(1'b1, 1'b0);
    total++;
    if (dut_vec !== {2'd1, 1'b1, 1'b0, 16'h9900}) begin bad++; $display("FAIL clamp_99 got=%h want=%h", dut_vec, {2'd1, 2'b10, 16'h9900}); end
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    total++;
    if (dut_vec !== exp_vec()) begin bad++; $display("FAIL clamp_cancel got=%h want=%h", dut_vec, exp_vec()); end
  endtask

  task automatic test_pause_resume();
    bit found;
    int want, n;
    tif.input_time = 10'd1;
    @(negedge clk);
    press(1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== exp_vec()) begin bad++; $display("FAIL pr_track got=%h want=%h", dut_vec, exp_vec()); end
      if (dut_vec[15:0] == 16'h0004) found = 1'b1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL reach_0004 got=timeout want=0004"); end
    repeat (2) @(negedge clk);
    tif.btnstop = 1'b0;
    repeat (4) @(negedge clk);
    tif.btnstop = 1'b1;
    total++;
    if (dut_vec !== {2'd2, 1'b0, 1'b0, 16'h0003}) begin bad++; $display("FAIL pause_entry got=%h want=%h", dut_vec, {2'd2, 2'b00, 16'h0003}); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== {2'd2, 1'b0, 1'b0, 16'h0003}) begin bad++; $display("FAIL pause_hold cyc=%0d got=%h want=%h", i, dut_vec, {2'd2, 2'b00, 16'h0003}); end
    end
    tif.btnstart = 1'b0;
    repeat (4) @(negedge clk);
    tif.btnstart = 1'b1;
    total++;
    if (tif.state !== 2'd1) begin bad++; $display("FAIL resume_state got=%0d want=1", tif.state); end
    want = CLK_HZ - m_phase;
    n = 0;
    while (dut_vec[15:0] == 16'h0003 && n < 2 * CLK_HZ) begin @(negedge clk); n++; end
    total++;
    if (n !== want || want >= CLK_HZ) begin bad++; $display("FAIL resume_tick got=%0d want=%0d", n, want); end
    total++;
    if (dut_vec[15:0] !== 16'h0002) begin bad++; $display("FAIL resume_digits got=%h want=0002", dut_vec[15:0]); end
  endtask

  task automatic test_done_alarm();
    bit found;
    int n;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (tif.state == 2'd3) found = 1'b1;
    end
    total++;
    if (!found || dut_vec !== {2'd3, 1'b0, 1'b1, 16'h0000}) begin bad++; $display("FAIL done_entry got=%h want=%h", dut_vec, {2'd3, 2'b01, 16'h0000}); end
    n = 0;
    while (tif.state == 2'd3 && n < 50) begin @(negedge clk); n++; end
    total++;
    if (n !== ALARM_SEC * CLK_HZ) begin bad++; $display("FAIL alarm_len got=%0d want=%0d", n, ALARM_SEC * CLK_HZ); end
    total++;
    if (tif.state !== 2'd0 || tif.alarm !== 1'b0) begin bad++; $display("FAIL alarm_exit got=%0d/%0d want=0/0", tif.state, tif.alarm); end
    tif.input_time = 10'd0;
    @(negedge clk);
    tif.input_time = 10'd1;
    @(negedge clk);
    press(1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== exp_vec()) begin bad++; $display("FAIL done2_track got=%h want=%h", dut_vec, exp_vec()); end
      if (tif.state == 2'd3) found = 1'b1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL done2_reach got=timeout want=3"); end
    tif.btnstop = 1'b0;
    n = 0;
    while (tif.state == 2'd3 && n < 10) begin @(negedge clk); n++; end
    tif.btnstop = 1'b1;
    total++;
    if (n !== 4 || tif.alarm !== 1'b0) begin bad++; $display("FAIL ack_latency got=%0d want=4", n); end
    repeat (2) @(negedge clk);
    total++;
    if (dut_vec !== exp_vec()) begin bad++; $display("FAIL ack_idle got=%h want=%h", dut_vec, exp_vec()); end
  endtask

  task automatic test_simultaneous();
    tif.input_time = 10'd2;
    @(negedge clk);
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    total++;
    if (tif.state !== 2'd2 || dut_vec !== exp_vec()) begin bad++; $display("FAIL both_pressed got=%h want=%h", dut_vec, exp_vec()); end
    press(1'b1, 1'b1);
    total++;
    if (tif.state !== 2'd0) begin bad++; $display("FAIL both_cancel got=%0d want=0", tif.state); end
  endtask

  task automatic test_reset_mid();
    tif.input_time = 10'd2;
    @(negedge clk);
    press(1'b1, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (dut_vec !== 20'h0) begin bad++; $display("FAIL mid_reset got=%h want=%h", dut_vec, 20'h0); end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (dut_vec !== {2'd0, 1'b0, 1'b0, 16'h0200} || dut_vec !== exp_vec()) begin bad++; $display("FAIL post_reset got=%h want=%h", dut_vec, exp_vec()); end
  endtask

  task automatic test_hold();
    int changes;
    logic [1:0] prev;
    tif.input_time = 10'd3;
    @(negedge clk);
    tif.btnstart = 1'b0;
    prev = tif.state;
    changes = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tif.state !== prev) changes++;
      prev = tif.state;
    end
    tif.btnstart = 1'b1;
    total++;
    if (changes !== 1 || tif.state !== 2'd1) begin bad++; $display("FAIL hold_once got=%0d/%0d want=1/1", changes, tif.state); end
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    total++;
    if (dut_vec !== exp_vec()) begin bad++; $display("FAIL hold_cancel got=%h want=%h", dut_vec, exp_vec()); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0)  tif.btnstart = ~tif.btnstart;
      if ($urandom_range(0, 29) == 0) tif.btnstop  = ~tif.btnstop;
      if ($urandom_range(0, 49) == 0)
        tif.input_time = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 2)) : 10'($urandom_range(0, 130));
      rst = ($urandom_range(0, 299) == 0);
      @(negedge clk);
      total++;
      if (dut_vec !== exp_vec()) begin bad++; $display("FAIL random cyc=%0d got=%h want=%h", i, dut_vec, exp_vec()); end
    end
    rst = 1'b0;
  endtask

  initial begin
    tif.btnstart   = 1'b1;
    tif.btnstop    = 1'b1;
    tif.input_time = 10'd5;
    test_reset();
    test_run_borrow();
    test_idle_edges();
    test_pause_resume();
    test_done_alarm();
    test_simultaneous();
    test_reset_mid();
    test_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
